// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO behind the 1G MAC: absorbs every beat, commits only
// complete good frames, and serves them on a backpressured AXI-Stream output.
`timescale 1ns/1ps
module eth_rx_frame_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 11,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  status_good_frame,
  output logic                  status_bad_frame,
  output logic                  status_overflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr_cur;
  logic [ADDR_WIDTH:0]   r_wr_ptr_commit;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_drop_flag;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_status_good;
  logic                  r_status_bad;
  logic                  r_status_ovf;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_bad_last;
  logic w_rd_load;

  // Full uses the registered read pointer, so a read in this cycle never frees room for this write.
  assign w_full     = (r_wr_ptr_cur - r_rd_ptr) == PTR_FULL;
  assign w_empty    = (r_rd_ptr == r_wr_ptr_commit);
  assign w_wr_en    = s_axis_tvalid && !r_drop_flag && !w_full;
  assign w_bad_last = DROP_BAD_FRAME && s_axis_tuser;
  assign w_rd_load  = (!r_m_tvalid || m_axis_tready) && !w_empty;

  // Write stage: frame accounting on each incoming beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr_cur    <= '0;
      r_wr_ptr_commit <= '0;
      r_drop_flag     <= 1'b0;
      r_status_good   <= 1'b0;
      r_status_bad    <= 1'b0;
      r_status_ovf    <= 1'b0;
    end else begin
      r_status_good <= 1'b0;
      r_status_bad  <= 1'b0;
      r_status_ovf  <= 1'b0;
      if (s_axis_tvalid) begin
        if (r_drop_flag) begin
          if (s_axis_tlast) begin
            r_drop_flag <= 1'b0;
          end
        end else if (w_full) begin
          r_wr_ptr_cur <= r_wr_ptr_commit;
          r_status_ovf <= 1'b1;
          r_drop_flag  <= !s_axis_tlast;
        end else if (!s_axis_tlast) begin
          r_wr_ptr_cur <= r_wr_ptr_cur + PTR_ONE;
        end else if (w_bad_last) begin
          r_wr_ptr_cur <= r_wr_ptr_commit;
          r_status_bad <= 1'b1;
        end else begin
          r_wr_ptr_cur    <= r_wr_ptr_cur + PTR_ONE;
          r_wr_ptr_commit <= r_wr_ptr_cur + PTR_ONE;
          r_status_good   <= 1'b1;
        end
      end
    end
  end

  // The last word of a dropped frame may land in memory; it sits beyond the commit pointer.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Read stage: single output register, reads stop at the commit pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else if (w_rd_load) begin
      {r_m_tlast, r_m_tdata} <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      r_rd_ptr               <= r_rd_ptr + PTR_ONE;
      r_m_tvalid             <= 1'b1;
    end else if (r_m_tvalid && m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata      = r_m_tdata;
  assign m_axis_tvalid     = r_m_tvalid;
  assign m_axis_tlast      = r_m_tlast;
  assign status_good_frame = r_status_good;
  assign status_bad_frame  = r_status_bad;
  assign status_overflow   = r_status_ovf;

endmodule
